// File: rtl/exmem_pkg.sv
// Shared types and constants for the Wishbone user-BRAM controller.
// Optional macro WB_EXMEM_PERF_EN (used in wb_exmem_ctrl) adds read/write counters.
package exmem_pkg;

    localparam int unsigned DLY_W         = 16;
    localparam logic [11:0] BASE_ADDR_DEF = 12'h380;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_ACCESS  = 3'd2,
        S_CAPTURE = 3'd3,
        S_ACK     = 3'd4
    } state_e;

    // Byte write enables for a latched request: reads never write any lane.
    function automatic logic [3:0] lane_we(input logic we, input logic [3:0] sel);
        return we ? sel : 4'b0000;
    endfunction

endpackage

// File: rtl/exmem_delay_cnt.sv
// Wait-state counter: counts DELAYS cycles after start, raises done on the last one.
module exmem_delay_cnt
    import exmem_pkg::*;
#(
    parameter int unsigned DELAYS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic done
);

    localparam logic [DLY_W-1:0] LAST = (DELAYS == 0) ? '0 : DLY_W'(DELAYS - 1);

    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    assign done = active_q && (cnt_q == LAST);

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (abort || done) begin
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (start) begin
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            cnt_d = cnt_q + DLY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/wb_exmem_ctrl.sv
// Wishbone slave in front of the user BRAM: decode, wait states, one access, one-cycle ack.
// Define WB_EXMEM_PERF_EN to add perf_rd_cnt / perf_wr_cnt transaction counters.
module wb_exmem_ctrl
    import exmem_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int unsigned DELAYS    = 10,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_a,
    output logic [31:0]       bram_di,
    input  logic [31:0]       bram_do,
`ifdef WB_EXMEM_PERF_EN
    output logic [31:0]       perf_rd_cnt,
    output logic [31:0]       perf_wr_cnt,
`endif
    output logic              busy
);

    state_e              state_q, state_d;
    logic                ack_q, ack_d;
    logic [31:0]         dat_o_q, dat_o_d;
    logic                bram_en_q, bram_en_d;
    logic [3:0]          bram_we_q, bram_we_d;
    logic [ADDR_W-1:0]   bram_a_q, bram_a_d;
    logic [31:0]         bram_di_q, bram_di_d;
    logic                busy_q, busy_d;
    logic [3:0]          sel_q, sel_d;
    logic                we_q, we_d;
    logic                dly_start, dly_abort, dly_done;
    logic                req;
    logic                unused_adr;

    assign req        = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:20] == BASE_ADDR);
    assign unused_adr = ^{wbs_adr_i[19:ADDR_W+2], wbs_adr_i[1:0]};

    exmem_delay_cnt #(.DELAYS(DELAYS)) u_dly (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .start (dly_start),
        .abort (dly_abort),
        .done  (dly_done)
    );

`ifdef WB_EXMEM_PERF_EN
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_wr_q, perf_wr_d;
    assign perf_rd_cnt = perf_rd_q;
    assign perf_wr_cnt = perf_wr_q;
`endif

    // Next state; outputs are registered decodes of the next state so they align with state_q.
    always_comb begin
        state_d   = state_q;
        dat_o_d   = dat_o_q;
        bram_a_d  = bram_a_q;
        bram_di_d = bram_di_q;
        sel_d     = sel_q;
        we_d      = we_q;
        dly_start = 1'b0;
        dly_abort = 1'b0;
`ifdef WB_EXMEM_PERF_EN
        perf_rd_d = perf_rd_q;
        perf_wr_d = perf_wr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    bram_a_d  = wbs_adr_i[ADDR_W+1:2];
                    bram_di_d = wbs_dat_i;
                    sel_d     = wbs_sel_i;
                    we_d      = wbs_we_i;
                    if (DELAYS > 0) begin
                        state_d   = S_WAIT;
                        dly_start = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d   = S_IDLE;
                    dly_abort = 1'b1;
                end else if (dly_done) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (!we_q) begin
                    dat_o_d = bram_do;
                end
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
`ifdef WB_EXMEM_PERF_EN
                if (we_q) begin
                    perf_wr_d = perf_wr_q + 32'd1;
                end else begin
                    perf_rd_d = perf_rd_q + 32'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        bram_en_d = (state_d == S_ACCESS);
        bram_we_d = bram_en_d ? lane_we(we_d, sel_d) : 4'b0000;
        ack_d     = (state_d == S_ACK);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            ack_q     <= 1'b0;
            dat_o_q   <= '0;
            bram_en_q <= 1'b0;
            bram_we_q <= '0;
            bram_a_q  <= '0;
            bram_di_q <= '0;
            busy_q    <= 1'b0;
            sel_q     <= '0;
            we_q      <= 1'b0;
`ifdef WB_EXMEM_PERF_EN
            perf_rd_q <= '0;
            perf_wr_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            dat_o_q   <= dat_o_d;
            bram_en_q <= bram_en_d;
            bram_we_q <= bram_we_d;
            bram_a_q  <= bram_a_d;
            bram_di_q <= bram_di_d;
            busy_q    <= busy_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
`ifdef WB_EXMEM_PERF_EN
            perf_rd_q <= perf_rd_d;
            perf_wr_q <= perf_wr_d;
`endif
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_o_q;
    assign bram_en   = bram_en_q;
    assign bram_we   = bram_we_q;
    assign bram_a    = bram_a_q;
    assign bram_di   = bram_di_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_wb_exmem_ctrl.sv
// Directed bench for wb_exmem_ctrl: DELAYS=10 and DELAYS=0 instances, each with a BRAM model.
module tb_wb_exmem_ctrl;

    localparam int WIN = 50;

    logic        clk = 1'b0;
    logic        rst, cyc, cyc0, stb, we;
    logic [3:0]  sel;
    logic [31:0] dat, adr;

    logic        ack_a, en_a, busy_a, ack_b, en_b, busy_b;
    logic [31:0] dato_a, di_a, do_a, dato_b, di_b, do_b;
    logic [3:0]  we_a, we_b;
    logic [9:0]  a_a, a_b;
`ifdef WB_EXMEM_PERF_EN
    logic [31:0] prd_a, pwr_a, prd_b, pwr_b;
`endif

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_exmem_ctrl #(.DELAYS(10)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr),
        .wbs_ack_o(ack_a), .wbs_dat_o(dato_a), .bram_en(en_a), .bram_we(we_a),
        .bram_a(a_a), .bram_di(di_a), .bram_do(do_a),
`ifdef WB_EXMEM_PERF_EN
        .perf_rd_cnt(prd_a), .perf_wr_cnt(pwr_a),
`endif
        .busy(busy_a)
    );

    wb_exmem_ctrl #(.DELAYS(0)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc0), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr),
        .wbs_ack_o(ack_b), .wbs_dat_o(dato_b), .bram_en(en_b), .bram_we(we_b),
        .bram_a(a_b), .bram_di(di_b), .bram_do(do_b),
`ifdef WB_EXMEM_PERF_EN
        .perf_rd_cnt(prd_b), .perf_wr_cnt(pwr_b),
`endif
        .busy(busy_b)
    );

    // Synchronous-read BRAM models with byte enables.
    always @(posedge clk) begin
        if (en_a) begin
            for (int b = 0; b < 4; b++)
                if (we_a[b]) mem_a[a_a][8*b +: 8] <= di_a[8*b +: 8];
            do_a <= mem_a[a_a];
        end
        if (en_b) begin
            for (int b = 0; b < 4; b++)
                if (we_b[b]) mem_b[a_b][8*b +: 8] <= di_b[8*b +: 8];
            do_b <= mem_b[a_b];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One Wishbone request; cycle k is the k-th cycle after the edge that samples the request.
    task automatic txn(input bit on0, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int abort_at, input int rst_at,
                       output int en_c, output int ack_c, output int ne, output int na,
                       output logic [9:0] ae, output logic [3:0] wee, output logic [31:0] die,
                       output logic [31:0] rd, output int bc);
        logic e, k_ack, bz;
        en_c = -1; ack_c = -1; ne = 0; na = 0; bc = 0;
        ae = '0; wee = '0; die = '0; rd = '0;
        @(negedge clk);
        we = w; adr = a; dat = d; sel = s; stb = 1'b1;
        if (on0) cyc0 = 1'b1; else cyc = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            e     = on0 ? en_b : en_a;
            k_ack = on0 ? ack_b : ack_a;
            bz    = on0 ? busy_b : busy_a;
            if (e) begin
                ne++;
                if (en_c < 0) begin
                    en_c = k;
                    ae   = on0 ? a_b : a_a;
                    wee  = on0 ? we_b : we_a;
                    die  = on0 ? di_b : di_a;
                end
            end
            if (k_ack) begin
                na++;
                if (ack_c < 0) begin
                    ack_c = k;
                    rd    = on0 ? dato_b : dato_a;
                    cyc = 1'b0; cyc0 = 1'b0; stb = 1'b0;
                end
            end
            if (bz) bc++;
            if (k == abort_at) begin
                cyc = 1'b0; cyc0 = 1'b0; stb = 1'b0;
            end
            if (k == rst_at) begin
                rst = 1'b1; cyc = 1'b0; cyc0 = 1'b0; stb = 1'b0;
            end else begin
                rst = 1'b0;
            end
        end
        cyc = 1'b0; cyc0 = 1'b0; stb = 1'b0;
    endtask

    int          en_c, ack_c, ne, na, bc;
    logic [9:0]  ae;
    logic [3:0]  wee;
    logic [31:0] die, rd;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        rst = 1'b1; cyc = 1'b0; cyc0 = 1'b0; stb = 1'b0; we = 1'b0;
        sel = '0; dat = '0; adr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(ack_a), 32'h0);
        chk("rst_dat", dato_a, 32'h0);
        chk("rst_en", 32'(en_a), 32'h0);
        chk("rst_we", 32'(we_a), 32'h0);
        chk("rst_a", 32'(a_a), 32'h0);
        chk("rst_di", di_a, 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        rst = 1'b0;

        // Full-word write, DELAYS=10
        txn(1'b0, 1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, en_c, ack_c, ne, na, ae, wee, die, rd, bc);
        chk("wr_en_cyc", 32'(en_c), 32'd11);
        chk("wr_a", 32'(ae), 32'd4);
        chk("wr_we", 32'(wee), 32'hF);
        chk("wr_di", die, 32'hDEAD_BEEF);
        chk("wr_ack_cyc", 32'(ack_c), 32'd13);
        chk("wr_n_en", 32'(ne), 32'd1);
        chk("wr_n_ack", 32'(na), 32'd1);
        chk("wr_busy", 32'(bc), 32'd13);

        // Read back
        txn(1'b0, 1'b0, 32'h3800_0010, 32'h0, 4'hF, 0, 0, en_c, ack_c, ne, na, ae, wee, die, rd, bc);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("rd_we", 32'(wee), 32'h0);
        chk("rd_ack_cyc", 32'(ack_c), 32'd13);
        chk("rd_n_en", 32'(ne), 32'd1);
        chk("rd_n_ack", 32'(na), 32'd1);

        // Byte-lane write over 0x11223344
        txn(1'b0, 1'b1, 32'h3800_0020, 32'h1122_3344, 4'hF, 0, 0, en_c, ack_c, ne, na, ae, wee, die, rd, bc);
        txn(1'b0, 1'b1, 32'h3800_0020, 32'h0000_AB00, 4'b0010, 0, 0, en_c, ack_c, ne, na, ae, wee, die, rd, bc);
        chk("bw_we", 32'(wee), 32'h2);
        txn(1'b0, 1'b0, 32'h3800_0020, 32'h0, 4'hF, 0, 0, en_c, ack_c, ne, na, ae, wee, die, rd, bc);
        chk("bw_data", rd, 32'h1122_AB44);

        // sel=0 write: access without lanes, still acked
        txn(1'b0, 1'b1, 32'h3800_0010, 32'h0, 4'h0, 0, 0, en_c, ack_c, ne, na, ae, wee, die, rd, bc);
        chk("sel0_n_en", 32'(ne), 32'd1);
        chk("sel0_we", 32'(wee), 32'h0);
        chk("sel0_ack_cyc", 32'(ack_c), 32'd13);

        // Address bit 12 ignored: aliases word 4
        txn(1'b0, 1'b0, 32'h3800_1010, 32'h0, 4'hF, 0, 0, en_c, ack_c, ne, na, ae, wee, die, rd, bc);
        chk("wrap_a", 32'(ae), 32'd4);
        chk("wrap_data", rd, 32'hDEAD_BEEF);

        // DELAYS=0 instance
        txn(1'b1, 1'b1, 32'h3800_0040, 32'hCAFE_F00D, 4'hF, 0, 0, en_c, ack_c, ne, na, ae, wee, die, rd, bc);
        chk("d0_wr_ack_cyc", 32'(ack_c), 32'd3);
        chk("d0_wr_a", 32'(ae), 32'h10);
        txn(1'b1, 1'b0, 32'h3800_0040, 32'h0, 4'hF, 0, 0, en_c, ack_c, ne, na, ae, wee, die, rd, bc);
        chk("d0_rd_en_cyc", 32'(en_c), 32'd1);
        chk("d0_rd_ack_cyc", 32'(ack_c), 32'd3);
        chk("d0_rd_data", rd, 32'hCAFE_F00D);
        chk("d0_busy", 32'(bc), 32'd3);

        // Non-matching address
        txn(1'b0, 1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 0, en_c, ack_c, ne, na, ae, wee, die, rd, bc);
        chk("nm_n_en", 32'(ne), 32'd0);
        chk("nm_n_ack", 32'(na), 32'd0);
        chk("nm_busy", 32'(bc), 32'd0);

        // Abort in WAIT cycle 5
        txn(1'b0, 1'b0, 32'h3800_0010, 32'h0, 4'hF, 5, 0, en_c, ack_c, ne, na, ae, wee, die, rd, bc);
        chk("ab_n_en", 32'(ne), 32'd0);
        chk("ab_n_ack", 32'(na), 32'd0);
        chk("ab_busy", 32'(bc), 32'd5);

        // Reset during CAPTURE of the next read
        txn(1'b0, 1'b0, 32'h3800_0010, 32'h0, 4'hF, 0, 12, en_c, ack_c, ne, na, ae, wee, die, rd, bc);
        chk("rs_en_cyc", 32'(en_c), 32'd11);
        chk("rs_n_ack", 32'(na), 32'd0);
        chk("rs_busy", 32'(busy_a), 32'h0);
        chk("rs_dat", dato_a, 32'h0);
`ifdef WB_EXMEM_PERF_EN
        chk("rs_perf_rd", prd_a, 32'h0);
        chk("rs_perf_wr", pwr_a, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_exmem_ctrl.md
Name: wb_exmem_ctrl

Overview:
- Wishbone slave memory controller placed directly upstream of the user-area BRAM macro.
- Decodes user-project Wishbone cycles and applies a programmable wait-state delay.
- Drives a single BRAM access per transaction, registers read data, and returns a one-cycle ACK.
- Lets firmware execute from, and store data in, user BRAM with deterministic latency.

Parameters:
- BASE_ADDR, 12'h380: match value for wbs_adr_i[31:20].
- DELAYS, 10: wait-state cycles inserted before the BRAM access; legal range 0..65535.
- ADDR_W, 10: BRAM word-address width. bram_a = latched wbs_adr_i[ADDR_W+1:2].

Ports:
- wb_clk_i  in  1  single clock; all logic on its rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte-lane select.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  registered read data.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  BRAM byte write enables.
- bram_a  out  ADDR_W  BRAM word address.
- bram_di  out  32  BRAM write data.
- bram_do  in  32  BRAM read data, valid the cycle after bram_en.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Request: req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20]==BASE_ADDR). Non-matching cycles are ignored and never acked.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, bram_en=0, bram_we=0, bram_a=0, bram_di=0, busy=0, state=IDLE, delay counter=0.
- FSM states: IDLE, WAIT, ACCESS, CAPTURE, ACK.
- IDLE: on req, latch address, data, sel and we. Go to WAIT if DELAYS>0, otherwise go to ACCESS.
- WAIT: the 16-bit counter increments each cycle. When counter==DELAYS-1, clear the counter and go to ACCESS.
- ACCESS: bram_en=1 for exactly one cycle. bram_we = latched sel when we=1, otherwise 4'b0. Go to CAPTURE.
- CAPTURE: for reads, wbs_dat_o <= bram_do. For writes, wbs_dat_o holds its previous value. Go to ACK.
- ACK: wbs_ack_o=1 for exactly one cycle, then go to IDLE.
  - A new req is accepted no earlier than the cycle after ACK, so no back-to-back ack is possible.
- Latency: req sampled in IDLE at edge N; ack is high in cycle N+DELAYS+3.
- Abort: if wbs_cyc_i falls in WAIT, return to IDLE next edge; no BRAM access and no ack.
  - Once ACCESS is entered the access completes. If cyc falls during CAPTURE or ACK, ack is still issued.
- bram_a wraps modulo 2^ADDR_W. Upper address bits between [ADDR_W+2] and [19] are ignored.
- wbs_sel_i=0 on a write gives a BRAM access with no bytes written; ack is still issued.
- Reset asserted mid-transaction: the next edge returns to IDLE with all outputs at reset values. No pending ack survives.
- Inputs changing after latch have no effect on the transaction in flight.

Optional Feature:
- Macro: WB_EXMEM_PERF_EN.
- Defined:
  - Adds output perf_rd_cnt[31:0] and perf_wr_cnt[31:0].
  - Each increments by 1 on the ACK cycle of a read or write respectively, wraps at 2^32, and resets to 0.
  - Aborted transactions are not counted.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package exmem_pkg holds:
  - FSM state encoding: IDLE=0, WAIT=1, ACCESS=2, CAPTURE=3, ACK=4, 3 bits.
  - BASE_ADDR default constant.
  - Counter width constant DLY_W=16.
- One sub-module, exmem_delay_cnt, implements the wait-state counter.
  - Inputs: start, abort.
  - Output: done.
  - Parameter: DELAYS.

Test Plan:
- Write 0xDEADBEEF, sel=4'hF, adr 0x38000010, DELAYS=10:
  - bram_en pulses in cycle N+11 with bram_a=4 and bram_we=4'hF.
  - ack in cycle N+13.
- Read adr 0x38000010 after the write above:
  - wbs_dat_o=0xDEADBEEF in the ack cycle.
  - Exactly one bram_en pulse and one ack pulse.
- Byte write: sel=4'b0010, data 0x0000AB00 over a word holding 0x11223344.
  - Read back 0x1122AB44.
- DELAYS=0 instance, read: ack at N+3.
- Request to 0x30000000: no bram_en and no ack over 50 cycles; busy stays 0.
- Abort: drop cyc in WAIT cycle 5 → no bram_en and no ack.
  - Then wb_rst_i during CAPTURE of the next read → ack never asserted, state IDLE.
  - With WB_EXMEM_PERF_EN: the counters show rd=0, wr=0 after the reset.
